// File: rtl/fuzz_sig_capture.sv
// Signature capture for fuzz-generated DUT outputs: folds a wide output vector into
// a MISR over a programmed window (after a warm-up skip) and compares to a golden value.
module fuzz_sig_capture #(
  parameter int                DATA_W = 386,
  parameter int                SIG_W  = 32,
  parameter int                CNT_W  = 16,
  parameter int                WARM   = 2,
  parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED   = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic [DATA_W-1:0] y_in,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  absorbed,
  output logic              match
);

  localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NCHUNK * SIG_W;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARM > 0) ? WARM - 1 : 0);

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  warm_cnt;
  logic [PAD_W-1:0]  y_pad;
  logic [SIG_W-1:0]  fold;
  logic [SIG_W-1:0]  misr_next;
  logic              accept;

  // The partial top chunk is zero-padded so every chunk folds uniformly.
  assign y_pad = PAD_W'(y_in);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    fold = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      fold = fold ^ y_pad[k*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ fold;

  assign accept = start && ((state == IDLE) || (state == DONE));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (num_cycles == '0) state_nxt = DONE;
          else if (WARM > 0)    state_nxt = WARMUP;
          else                  state_nxt = CAPTURE;
        end
      end
      WARMUP:  if (warm_cnt == WARM_LAST)                 state_nxt = CAPTURE;
      CAPTURE: if (remaining == CNT_W'(1))                state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; only match looks at an input.
  always_comb begin
    busy  = (state == WARMUP) || (state == CAPTURE);
    done  = (state == DONE);
    match = done && (signature == expected_sig);
  end

  // Datapath: counters and the MISR; start in busy states is simply not accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= '0;
      absorbed  <= '0;
      remaining <= '0;
      warm_cnt  <= '0;
    end else if (accept) begin
      signature <= SEED;
      absorbed  <= '0;
      remaining <= num_cycles;
      warm_cnt  <= '0;
    end else if (state == WARMUP) begin
      warm_cnt  <= warm_cnt + CNT_W'(1);
    end else if (state == CAPTURE) begin
      signature <= misr_next;
      remaining <= remaining - CNT_W'(1);
      if (absorbed != '1) absorbed <= absorbed + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fuzz_sig_capture.sv
// Randomized and directed bench for fuzz_sig_capture: three instances with different
// warm-up/seed settings share stimulus and are scored against a bit-level reference model.
module tb_fuzz_sig_capture;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  typedef logic [385:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_cycles = '0;
  vec_t        y_in = '0;
  logic [31:0] expected_sig = '0;

  logic        busy [3];
  logic        done [3];
  logic [31:0] signature [3];
  logic [15:0] absorbed [3];
  logic        match [3];

  int checks = 0;
  int errors = 0;
  vec_t stim[$];

  always #5 clk = ~clk;

  fuzz_sig_capture #(.WARM(0), .SEED(32'h00000000)) dut_w0 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .y_in(y_in),
    .expected_sig(expected_sig), .busy(busy[0]), .done(done[0]),
    .signature(signature[0]), .absorbed(absorbed[0]), .match(match[0]));

  fuzz_sig_capture #(.WARM(2), .SEED(32'h00000000)) dut_w2 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .y_in(y_in),
    .expected_sig(expected_sig), .busy(busy[1]), .done(done[1]),
    .signature(signature[1]), .absorbed(absorbed[1]), .match(match[1]));

  fuzz_sig_capture #(.WARM(0), .SEED(32'h80000000)) dut_s8 (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .y_in(y_in),
    .expected_sig(expected_sig), .busy(busy[2]), .done(done[2]),
    .signature(signature[2]), .absorbed(absorbed[2]), .match(match[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int warm_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic logic [31:0] seed_of(input int i);
    return (i == 2) ? 32'h80000000 : 32'h00000000;
  endfunction

  // Bit i of the vector lands on signature bit (i mod 32).
  function automatic logic [31:0] fold_ref(input vec_t v);
    logic [31:0] r = '0;
    for (int i = 0; i < 386; i++) r[i % 32] = r[i % 32] ^ v[i];
    return r;
  endfunction

  // Instance i absorbs the n samples that follow its warm-up skip.
  function automatic logic [31:0] model_sig(input int i, input int n);
    logic [31:0] s = seed_of(i);
    for (int j = 0; j < n; j++) begin
      int   idx = warm_of(i) + j;
      vec_t v   = (idx < stim.size()) ? stim[idx] : '0;
      logic msb = s[31];
      s = (s << 1) ^ fold_ref(v);
      if (msb) s = s ^ POLY;
    end
    return s;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v = '0;
    for (int j = 0; j < 13; j++) v = (v << 32) | vec_t'($urandom);
    return v;
  endfunction

  task automatic check_final(input string tag, input int n);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e = model_sig(i, n);
      check($sformatf("%s.sig%0d", tag, i), signature[i], e);
      check($sformatf("%s.abs%0d", tag, i), absorbed[i], n);
      check($sformatf("%s.done%0d", tag, i), done[i], 1);
      check($sformatf("%s.busy%0d", tag, i), busy[i], 0);
      check($sformatf("%s.match%0d", tag, i), match[i], e == expected_sig);
    end
  endtask

  // Start at edge T, then drive stim over n+2 edges (enough for the warm-up instance).
  task automatic run(input string tag, input int n, input bit poke);
    num_cycles = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.go_busy%0d", tag, i), busy[i], n > 0);
      check($sformatf("%s.go_done%0d", tag, i), done[i], n == 0);
    end
    for (int k = 0; k < n + 2; k++) begin
      y_in = (k < stim.size()) ? stim[k] : '0;
      if (poke && (k == 1 || k == 2)) begin
        start = 1'b1; num_cycles = 16'd1;
      end else begin
        start = 1'b0; num_cycles = 16'(n);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_final(tag, n);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle.busy%0d", i), busy[i], 0);
      check($sformatf("idle.done%0d", i), done[i], 0);
      check($sformatf("idle.sig%0d", i), signature[i], 0);
      check($sformatf("idle.abs%0d", i), absorbed[i], 0);
      check($sformatf("idle.match%0d", i), match[i], 0);
    end

    // Single-bit folding.
    stim = '{vec_t'(1)};
    run("fold_b0", 1, 0);
    check("fold_b0.const", signature[0], 32'h00000001);
    v = '0; v[32] = 1'b1; stim = '{v};
    run("fold_b32", 1, 0);
    check("fold_b32.const", signature[0], 32'h00000001);
    v = '0; v[384] = 1'b1; stim = '{v};
    run("fold_b384", 1, 0);
    check("fold_b384.const", signature[0], 32'h00000001);
    v = '0; v[0] = 1'b1; v[32] = 1'b1; stim = '{v};
    run("fold_b0_32", 1, 0);
    check("fold_b0_32.const", signature[0], 32'h00000000);

    // Shift and feedback.
    stim = '{vec_t'(1), vec_t'(0)};
    run("shift", 2, 0);
    check("shift.const", signature[0], 32'h00000002);
    check("shift.abs", absorbed[0], 2);
    stim = '{vec_t'(0)};
    run("feedback", 1, 0);
    check("feedback.const", signature[2], 32'h04C11DB7);

    // Warm-up skip on the WARM=2 instance.
    stim = '{vec_t'(1), vec_t'(1), vec_t'(0)};
    num_cycles = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("warm.busy_t0", busy[1], 1);
    y_in = stim[0]; @(posedge clk); #1;
    check("warm.busy_t1", busy[1], 1);
    y_in = stim[1]; @(posedge clk); #1;
    check("warm.busy_t2", busy[1], 1);
    check("warm.done_t2", done[1], 0);
    y_in = stim[2]; @(posedge clk); #1;
    check("warm.busy_t3", busy[1], 0);
    check("warm.done_t3", done[1], 1);
    check("warm.sig", signature[1], 32'h00000000);

    // Zero-length run, start pulses while busy, restart from DONE.
    run("zero", 0, 0);
    check("zero.sig_seed", signature[2], 32'h80000000);
    stim = {};
    for (int k = 0; k < 8; k++) stim.push_back(rand_vec());
    run("poke", 6, 1);
    run("restart", 3, 0);

    // Compare against golden, then flip one bit.
    stim = {};
    for (int k = 0; k < 7; k++) stim.push_back(rand_vec());
    expected_sig = model_sig(0, 5);
    run("cmp", 5, 0);
    check("cmp.match_hit", match[0], 1);
    expected_sig = expected_sig ^ 32'h00010000;
    #1;
    check("cmp.match_miss", match[0], 0);

    // Asynchronous reset mid-capture, then a fresh run.
    num_cycles = 16'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      y_in = stim[k]; @(posedge clk); #1;
    end
    check("rst.pre_busy", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.busy%0d", i), busy[i], 0);
      check($sformatf("rst.done%0d", i), done[i], 0);
      check($sformatf("rst.sig%0d", i), signature[i], 0);
      check($sformatf("rst.abs%0d", i), absorbed[i], 0);
      check($sformatf("rst.match%0d", i), match[i], 0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run("after_rst", 5, 0);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(0, 9);
      stim = {};
      for (int k = 0; k < n + 2; k++) stim.push_back(rand_vec());
      expected_sig = $urandom_range(0, 1) ? model_sig($urandom_range(0, 2), n) : $urandom;
      run($sformatf("rnd%0d", r), n, $urandom_range(0, 1) == 1 && n >= 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
